// File: rtl/sent_pkg.sv
// Shared definitions for the SENT frame scheduler slice.
//   CH_W          : width of a channel index on the frame/issue buses
//   DATA_W        : width of a SENT frame payload
//   sched_state_e : issue FSM states (idle/arbitrate, issue pulse, wait for take)
package sent_pkg;

    localparam int unsigned CH_W   = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sent_frame_sched_if.sv
// Bus bundle between decoder, scheduler and frame generators.
//   frame_vld/frame_channel/frame_data : frame write strobe from the decoder
//   ch_ready                           : per-channel generator ready level
//   issue_vld/issue_channel/issue_data : single shared issue bus
//   pending, drop_cnt, err_chan, err_timeout : scheduler status
// master : the environment (decoder + generators)
// slave  : the scheduler
interface sent_frame_sched_if
    import sent_pkg::*;
#(
    parameter int unsigned SENT_NUM = 1,
    parameter int unsigned CNT_W    = 16
);

    logic                frame_vld;
    logic [CH_W-1:0]     frame_channel;
    logic [DATA_W-1:0]   frame_data;
    logic [SENT_NUM-1:0] ch_ready;

    logic                issue_vld;
    logic [CH_W-1:0]     issue_channel;
    logic [DATA_W-1:0]   issue_data;
    logic [SENT_NUM-1:0] pending;
    logic [CNT_W-1:0]    drop_cnt;
    logic                err_chan;
    logic                err_timeout;

    modport master (
        output frame_vld, frame_channel, frame_data, ch_ready,
        input  issue_vld, issue_channel, issue_data, pending, drop_cnt,
               err_chan, err_timeout
    );

    modport slave (
        input  frame_vld, frame_channel, frame_data, ch_ready,
        output issue_vld, issue_channel, issue_data, pending, drop_cnt,
               err_chan, err_timeout
    );

endinterface

// File: rtl/sent_rr_arb.sv
// Combinational round-robin arbiter.
//   req_i         : request vector, one bit per channel
//   ptr_i         : highest-priority channel (must be < SENT_NUM)
//   grant_valid_o : at least one request present
//   grant_idx_o   : first requesting channel at or above ptr_i, with wrap
module sent_rr_arb
    import sent_pkg::*;
#(
    parameter int unsigned SENT_NUM = 1
) (
    input  logic [SENT_NUM-1:0] req_i,
    input  logic [CH_W-1:0]     ptr_i,
    output logic                grant_valid_o,
    output logic [CH_W-1:0]     grant_idx_o
);

    int unsigned         idx;
    logic [SENT_NUM-1:0] req_sh;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        req_sh        = '0;
        for (int unsigned off = 0; off < SENT_NUM; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= SENT_NUM) begin
                idx = idx - SENT_NUM;
            end
            // shift instead of a variable bit-select keeps SENT_NUM=1 legal
            req_sh = req_i >> idx;
            if (!grant_valid_o && req_sh[0]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sent_frame_sched.sv
// Per-channel SENT frame scheduler: one pending frame slot per channel,
// round-robin grant of a shared issue bus, issue only to ready generators,
// then wait for the generator to drop ready (take the frame) or time out.
//   clk : clock
//   rst : asynchronous reset, active low
//   bus : sent_frame_sched_if.slave (frame writes, ready, issue bus, status)
module sent_frame_sched
    import sent_pkg::*;
#(
    parameter int unsigned SENT_NUM    = 1,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    sent_frame_sched_if.slave  bus
);

    localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    sched_state_e        state_q, state_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     issue_ch_q, issue_ch_d;
    logic [DATA_W-1:0]   issue_data_q, issue_data_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                err_timeout_q, err_timeout_d;
    logic [SENT_NUM-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                err_chan_q, err_chan_d;
    logic [DATA_W-1:0]   slot_q [SENT_NUM];

    logic                wr_ok;
    logic [SENT_NUM-1:0] wr_sel;
    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_fire;
    logic [DATA_W-1:0]   grant_data;
    logic [SENT_NUM-1:0] ready_sh;
    logic                sel_ready;

    assign wr_ok = bus.frame_vld && (bus.frame_channel < CH_W'(SENT_NUM));

    sent_rr_arb #(
        .SENT_NUM (SENT_NUM)
    ) u_arb (
        .req_i         (pending_q & bus.ch_ready),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign ready_sh  = bus.ch_ready >> issue_ch_q;
    assign sel_ready = ready_sh[0];

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < SENT_NUM; i++) begin
            if (grant_idx == CH_W'(i)) begin
                grant_data = slot_q[i];
            end
        end
    end

    // Issue FSM
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        issue_ch_d    = issue_ch_q;
        issue_data_d  = issue_data_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_timeout_d = err_timeout_q;
        grant_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    grant_fire   = 1'b1;
                    issue_ch_d   = grant_idx;
                    issue_data_d = grant_data;
                    rr_ptr_d     = (grant_idx == CH_W'(SENT_NUM - 1)) ? '0
                                                                      : grant_idx + CH_W'(1);
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (!sel_ready) begin
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    // frame is abandoned, not re-queued
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slot bookkeeping. A write in the same cycle as a grant of that channel
    // refills the slot (grant has already taken the old data) and is not a drop.
    always_comb begin
        pending_d  = pending_q;
        drop_cnt_d = drop_cnt_q;
        wr_sel     = '0;
        err_chan_d = bus.frame_vld && !wr_ok;
        for (int unsigned i = 0; i < SENT_NUM; i++) begin
            if (grant_fire && (grant_idx == CH_W'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (wr_ok && (bus.frame_channel == CH_W'(i))) begin
                wr_sel[i]    = 1'b1;
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(grant_fire && (grant_idx == CH_W'(i)))
                    && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            issue_ch_q    <= '0;
            issue_data_q  <= '0;
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
            pending_q     <= '0;
            drop_cnt_q    <= '0;
            err_chan_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_ch_q    <= issue_ch_d;
            issue_data_q  <= issue_data_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
            pending_q     <= pending_d;
            drop_cnt_q    <= drop_cnt_d;
            err_chan_q    <= err_chan_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SENT_NUM; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < SENT_NUM; i++) begin
                if (wr_sel[i]) begin
                    slot_q[i] <= bus.frame_data;
                end
            end
        end
    end

    assign bus.issue_vld     = (state_q == S_ISSUE);
    assign bus.issue_channel = issue_ch_q;
    assign bus.issue_data    = issue_data_q;
    assign bus.pending       = pending_q;
    assign bus.drop_cnt      = drop_cnt_q;
    assign bus.err_chan      = err_chan_q;
    assign bus.err_timeout   = err_timeout_q;

endmodule

// File: doc/sent_frame_sched.md
Name: sent_frame_sched

Overview:
Per-channel frame scheduler between the SENT parameter/frame decoder and the SENT frame generators. It holds one pending 32-bit frame per channel and grants a single shared issue bus to one channel at a time, in round-robin order. It issues a frame only to a generator that reports ready, then waits for that generator to take it. Overwritten frames, invalid channel indices and handshake timeouts are reported as status.

Parameters:
SENT_NUM, 1, number of SENT channels (1..32)
ACK_TIMEOUT, 255, clk cycles to wait for the selected ch_ready to fall after an issue
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  module clock
rst  in  1  asynchronous reset, active-low; all state clears while rst=0
frame_vld  in  1  one-cycle write strobe for a new frame
frame_channel  in  8  target channel index of the write
frame_data  in  32  frame payload
ch_ready  in  SENT_NUM  per-channel generator idle/ready, level
issue_vld  out  1  one-cycle issue pulse
issue_channel  out  8  channel index of the issued frame
issue_data  out  32  issued frame payload
pending  out  SENT_NUM  per-channel slot-occupied flags
drop_cnt  out  CNT_W  saturating count of overwritten pending frames
err_chan  out  1  one-cycle pulse: write with frame_channel >= SENT_NUM
err_timeout  out  1  sticky: ch_ready did not fall within ACK_TIMEOUT; cleared only by reset

Behaviour:
- Reset values: issue_vld=0, issue_channel=0, issue_data=0, pending=0, drop_cnt=0, err_chan=0, err_timeout=0, FSM=S_IDLE, RR pointer=0, timeout counter=0.
- Write path:
  - frame_vld with frame_channel < SENT_NUM stores frame_data in slot[ch] and sets pending[ch] on the next edge.
  - If pending[ch] was already 1 and is not being consumed that cycle, the old data is overwritten and drop_cnt increments, saturating at all-ones.
  - frame_channel >= SENT_NUM: write ignored; err_chan pulses on the next cycle.
- FSM S_IDLE:
  - Eligible channels are those with pending[i] & ch_ready[i].
  - Arbitration is round-robin, searching from RR pointer upward with wrap.
  - If any channel is eligible: latch its index and slot data into the issue registers, clear pending[i], set RR pointer to i+1 (wrapping to 0 after SENT_NUM-1), go to S_ISSUE.
  - Otherwise stay in S_IDLE.
- FSM S_ISSUE:
  - issue_vld=1 for exactly this one cycle, with issue_channel and issue_data stable.
  - Next state S_WAIT; timeout counter is loaded with 0.
- FSM S_WAIT:
  - issue_channel and issue_data hold their values.
  - If ch_ready[issue_channel]=0: go to S_IDLE.
  - Else if counter == ACK_TIMEOUT-1: set err_timeout, go to S_IDLE. The frame is considered lost and is not re-queued.
  - Else increment the counter.
- Latency: a write to an idle, ready channel with the FSM in S_IDLE produces issue_vld 2 cycles after the frame_vld edge (cycle 1 slot write, cycle 2 grant, cycle 3 pulse). Worst-case throughput is one issue per 3 cycles.
- Simultaneous write and grant on the same channel:
  - The grant captures the old slot data.
  - The new write refills the slot and pending[ch] stays 1.
  - No drop is counted.
- Only one frame is outstanding at a time. Writes to any channel are accepted in every FSM state.
- Asynchronous reset mid-transaction aborts the issue. No partial issue_vld is produced after reset is released.

Decomposition:
- Shared package sent_pkg: FSM state encoding (S_IDLE, S_ISSUE, S_WAIT), channel index width (8), frame data width (32).
- One natural sub-module, sent_rr_arb: SENT_NUM-wide round-robin arbiter. Inputs: request vector and pointer. Outputs: grant_valid and grant index. Purely combinational.

Test Plan:
- Single issue: SENT_NUM=4, ch_ready=4'hF, write ch2 data 32'hA5A5_0001.
  - Expect issue_vld 2 cycles later with issue_channel=2 and that data.
  - Drop ch_ready[2] on the next cycle: FSM returns to S_IDLE, pending=0.
- Round-robin: preload ch0, ch1, ch3 while ch_ready=0, then set ch_ready=4'hF.
  - Expect issue order 0, 1, 3, with each generator dropping ready after its issue.
  - Reload ch0 and ch3 with RR pointer at 0: expect order 0, 3.
- Overwrite: with ch_ready[1]=0, write ch1 three times (D1, D2, D3).
  - Expect drop_cnt=2 and pending[1]=1.
  - Raise ready: only D3 is issued.
- Invalid index: write ch 8'd7 with SENT_NUM=4.
  - Expect a one-cycle err_chan pulse, pending unchanged, no issue.
- Timeout: ACK_TIMEOUT=8, issue to ch0 with ch_ready[0] held high.
  - Expect err_timeout set 8 cycles after the issue pulse, then FSM in S_IDLE.
  - A further pending ch1 frame is still issued.
- Reset mid-S_WAIT: assert rst low asynchronously.
  - All outputs clear immediately.
  - After release with no writes, no issue_vld occurs.
